// File: rtl/si_payload_pkg.sv
// Shared types and constants for the time-tag payload extraction stage.
package si_payload_pkg;
  typedef enum logic {HDR, PAYLOAD} payload_state_t;

  localparam int TAG_WIDTH     = 64;
  localparam int TAGS_PER_BEAT = 2;
  localparam int DATA_W        = TAG_WIDTH * TAGS_PER_BEAT;
  localparam int KEEP_W        = DATA_W / 8;

  localparam logic [15:0] KEEP_ONE_TAG  = 16'h00FF;
  localparam logic [15:0] KEEP_TWO_TAGS = 16'hFFFF;

  localparam int HEADER_WORDS_DEFAULT = 2;
  localparam int SEQ_LSB_DEFAULT      = 64;

  // A payload beat must carry either one whole tag or two.
  function automatic logic keep_aligned(input logic [15:0] keep);
    return (keep == KEEP_ONE_TAG) || (keep == KEEP_TWO_TAGS);
  endfunction
endpackage

// File: rtl/si_axis_skid_slice.sv
// Generic 2-entry AXI-Stream register slice: main + skid register, registered upstream ready.
module si_axis_skid_slice #(
  parameter int DATA_W = 128,
  parameter int KEEP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEEP_W-1:0] in_keep,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic              out_last
);
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [KEEP_W-1:0] skid_keep;
  logic              skid_last;
  logic              in_fire, main_free;

  assign in_fire   = in_valid && in_ready;
  assign main_free = !out_valid || out_ready;

  // in_ready always mirrors !skid_valid, so a full skid never sees an input fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
      out_data   <= '0;
      out_keep   <= '0;
      out_last   <= 1'b0;
      skid_data  <= '0;
      skid_keep  <= '0;
      skid_last  <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        out_keep   <= skid_keep;
        out_last   <= skid_last;
        skid_valid <= 1'b0;
        in_ready   <= 1'b1;
      end else begin
        out_valid <= in_fire;
        if (in_fire) begin
          out_data <= in_data;
          out_keep <= in_keep;
          out_last <= in_last;
        end
      end
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
      skid_keep  <= in_keep;
      skid_last  <= in_last;
      in_ready   <= 1'b0;
    end
  end
endmodule

// File: rtl/si_payload_extractor.sv
// Strips header beats from time-tag packets, captures the sequence number and
// forwards payload beats through a registered slice.
module si_payload_extractor
  import si_payload_pkg::*;
#(
  parameter int HEADER_WORDS = HEADER_WORDS_DEFAULT,  // 2 or 3
  parameter int SEQ_WORD     = 1,
  parameter int SEQ_LSB      = SEQ_LSB_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [KEEP_W-1:0] s_axis_tkeep,
  input  logic              s_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  output logic [31:0]       seq_number,
  output logic              seq_valid,
  output logic              runt_packet,
  output logic              misaligned_tag,
  output logic [31:0]       packet_count
);
  localparam logic [1:0] LAST_HDR = 2'(HEADER_WORDS - 1);
  localparam logic [1:0] SEQ_IDX  = 2'(SEQ_WORD);

  payload_state_t state;
  logic [1:0]     word_idx;
  logic           first_payload;
  logic           accept, fwd_valid;

  assign accept       = s_axis_tvalid && s_axis_tready;
  assign fwd_valid    = s_axis_tvalid && (state == PAYLOAD);
  assign m_axis_tuser = 1'b0;

  // Header beats are gated only by the slice's ready, never by downstream.
  si_axis_skid_slice #(.DATA_W(DATA_W), .KEEP_W(KEEP_W)) u_slice (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (fwd_valid),
    .in_ready  (s_axis_tready),
    .in_data   (s_axis_tdata),
    .in_keep   (s_axis_tkeep),
    .in_last   (s_axis_tlast),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready),
    .out_data  (m_axis_tdata),
    .out_keep  (m_axis_tkeep),
    .out_last  (m_axis_tlast)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= HDR;
      word_idx       <= '0;
      first_payload  <= 1'b0;
      seq_number     <= '0;
      seq_valid      <= 1'b0;
      runt_packet    <= 1'b0;
      misaligned_tag <= 1'b0;
      packet_count   <= '0;
    end else begin
      seq_valid      <= 1'b0;
      runt_packet    <= 1'b0;
      misaligned_tag <= 1'b0;
      if (accept) begin
        case (state)
          HDR: begin
            // Captured even if this packet turns out to be a runt.
            if (word_idx == SEQ_IDX) begin
              seq_number <= s_axis_tdata[SEQ_LSB +: 32];
              seq_valid  <= 1'b1;
            end
            if (s_axis_tlast) begin
              runt_packet <= 1'b1;
              word_idx    <= '0;
            end else if (word_idx == LAST_HDR) begin
              state         <= PAYLOAD;
              word_idx      <= '0;
              first_payload <= 1'b1;
            end else begin
              word_idx <= word_idx + 2'd1;
            end
          end
          PAYLOAD: begin
            misaligned_tag <= !keep_aligned(s_axis_tkeep);
            if (first_payload) begin
              packet_count  <= packet_count + 32'd1;
              first_payload <= 1'b0;
            end
            if (s_axis_tlast) state <= HDR;
          end
          default: state <= HDR;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_si_payload_extractor.sv
// Directed self-checking bench for si_payload_extractor.
module tb_si_payload_extractor;
  logic         clk = 1'b0;
  logic         rst;
  logic         s_tvalid, s_tready, s_tlast;
  logic [127:0] s_tdata;
  logic [15:0]  s_tkeep;
  logic         m_tvalid, m_tready, m_tlast, m_tuser;
  logic [127:0] m_tdata;
  logic [15:0]  m_tkeep;
  logic [31:0]  seq_number, packet_count;
  logic         seq_valid, runt_packet, misaligned_tag;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  si_payload_extractor dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
    .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .seq_number(seq_number), .seq_valid(seq_valid), .runt_packet(runt_packet),
    .misaligned_tag(misaligned_tag), .packet_count(packet_count)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [127:0] d, input logic [15:0] k, input logic l);
    s_tvalid = v; s_tdata = d; s_tkeep = k; s_tlast = l;
  endtask

  task automatic beat(input logic [127:0] d, input logic [15:0] k, input logic l);
    drive(1'b1, d, k, l);
    cyc();
    drive(1'b0, '0, '0, 1'b0);
  endtask

  function automatic logic [127:0] hdr1(input logic [31:0] seq);
    return {32'hAAAA_0001, seq, 64'h1111_2222_3333_4444};
  endfunction

  localparam logic [127:0] H0  = 128'hDEAD_BEEF_0000_0000_CAFE_F00D_0000_0000;
  localparam logic [127:0] P0A = 128'h0000_0000_0000_0A01_0000_0000_0000_0A00;
  localparam logic [127:0] P1A = 128'h0000_0000_0000_0A03_0000_0000_0000_0A02;
  localparam logic [127:0] P2A = 128'h0000_0000_0000_0A05_0000_0000_0000_0A04;
  localparam logic [127:0] P0B = 128'h0000_0000_0000_0B01_0000_0000_0000_0B00;
  localparam logic [127:0] P1B = 128'h0000_0000_0000_0B03_0000_0000_0000_0B02;
  localparam logic [127:0] P2B = 128'h0000_0000_0000_0B05_0000_0000_0000_0B04;
  localparam logic [127:0] P0C = 128'h0000_0000_0000_0C01_0000_0000_0000_0C00;
  localparam logic [127:0] P0D = 128'h0000_0000_0000_0D01_0000_0000_0000_0D00;
  localparam logic [127:0] P1D = 128'h0000_0000_0000_0D03_0000_0000_0000_0D02;
  localparam logic [127:0] P0E = 128'h0000_0000_0000_0E01_0000_0000_0000_0E00;
  localparam logic [127:0] P1E = 128'h0000_0000_0000_0E03_0000_0000_0000_0E02;
  localparam logic [127:0] P0F = 128'h0000_0000_0000_0F01_0000_0000_0000_0F00;

  initial begin
    rst = 1'b1; m_tready = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_s_tready", s_tready, 1);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_seq", seq_number, 0);
    chk("rst_count", packet_count, 0);
    chk("rst_flags", {seq_valid, runt_packet, misaligned_tag}, 0);
    chk("tuser", m_tuser, 0);

    // Basic packet: 2 header + 3 payload beats, downstream always ready
    beat(H0, 16'hFFFF, 0);
    chk("p1_h0_nofwd", m_tvalid, 0);
    chk("p1_h0_seqv", seq_valid, 0);
    beat(hdr1(32'h0000_0005), 16'hFFFF, 0);
    chk("p1_seqv", seq_valid, 1);
    chk("p1_seq", seq_number, 32'h5);
    chk("p1_h1_nofwd", m_tvalid, 0);
    beat(P0A, 16'hFFFF, 0);
    chk("p1_b0_vld", m_tvalid, 1);
    chk("p1_b0_data", m_tdata, P0A);
    chk("p1_seqv_once", seq_valid, 0);
    chk("p1_count", packet_count, 1);
    beat(P1A, 16'hFFFF, 0);
    chk("p1_b1_data", m_tdata, P1A);
    chk("p1_b1_last", m_tlast, 0);
    beat(P2A, 16'hFFFF, 1);
    chk("p1_b2_data", m_tdata, P2A);
    chk("p1_b2_last", m_tlast, 1);
    cyc();
    chk("p1_idle_vld", m_tvalid, 0);
    chk("p1_idle_count", packet_count, 1);

    // Backpressure: m_tready 1,0,0,1,0,1 while payload is offered
    beat(H0, 16'hFFFF, 0);
    beat(hdr1(32'h0000_0006), 16'hFFFF, 0);
    m_tready = 1; drive(1, P0B, 16'hFFFF, 0); cyc();
    chk("st_a_data", m_tdata, P0B);
    chk("st_a_rdy", s_tready, 1);
    chk("st_a_count", packet_count, 2);
    m_tready = 0; drive(1, P1B, 16'hFFFF, 0); cyc();
    chk("st_b_data", m_tdata, P0B);
    chk("st_b_rdy", s_tready, 0);
    m_tready = 0; drive(1, P2B, 16'hFFFF, 1); cyc();
    chk("st_c_vld", m_tvalid, 1);
    chk("st_c_data", m_tdata, P0B);
    chk("st_c_rdy", s_tready, 0);
    m_tready = 1; cyc();
    chk("st_d_data", m_tdata, P1B);
    chk("st_d_rdy", s_tready, 1);
    m_tready = 0; cyc();
    drive(0, '0, '0, 0);
    chk("st_e_data", m_tdata, P1B);
    chk("st_e_rdy", s_tready, 0);
    m_tready = 1; cyc();
    chk("st_f_data", m_tdata, P2B);
    chk("st_f_last", m_tlast, 1);
    chk("st_f_rdy", s_tready, 1);
    cyc();
    chk("st_g_vld", m_tvalid, 0);

    // Runt: tlast on header beat 1
    beat(H0, 16'hFFFF, 0);
    beat(hdr1(32'h0000_0009), 16'hFFFF, 1);
    chk("runt_pulse", runt_packet, 1);
    chk("runt_seqv", seq_valid, 1);
    chk("runt_seq", seq_number, 32'h9);
    chk("runt_nofwd", m_tvalid, 0);
    cyc();
    chk("runt_once", {runt_packet, seq_valid}, 0);
    chk("runt_count", packet_count, 2);
    beat(H0, 16'hFFFF, 0);
    chk("post_runt_h0", m_tvalid, 0);
    beat(hdr1(32'h0000_000A), 16'hFFFF, 0);
    chk("post_runt_seq", seq_number, 32'hA);
    chk("post_runt_norunt", runt_packet, 0);
    beat(P0C, 16'hFFFF, 1);
    chk("single_data", m_tdata, P0C);
    chk("single_last", m_tlast, 1);
    chk("single_count", packet_count, 3);
    cyc();
    chk("single_once", m_tvalid, 0);

    // Misaligned tkeep
    beat(H0, 16'hFFFF, 0);
    beat(hdr1(32'h0000_000B), 16'hFFFF, 0);
    beat(P0D, 16'h000F, 0);
    chk("mis_pulse", misaligned_tag, 1);
    chk("mis_keep", m_tkeep, 16'h000F);
    chk("mis_data", m_tdata, P0D);
    beat(P1D, 16'h00FF, 1);
    chk("mis_none", misaligned_tag, 0);
    chk("mis_keep2", m_tkeep, 16'h00FF);
    chk("mis_count", packet_count, 4);
    cyc();

    // Counter wrap
    force dut.packet_count = 32'hFFFF_FFFF;
    #2;
    release dut.packet_count;
    chk("wrap_pre", packet_count, 32'hFFFF_FFFF);
    beat(H0, 16'hFFFF, 0);
    beat(hdr1(32'h0000_000C), 16'hFFFF, 0);
    beat(P0C, 16'hFFFF, 1);
    chk("wrap_count", packet_count, 0);
    cyc();

    // Reset while the skid holds a beat mid-packet
    m_tready = 0;
    beat(H0, 16'hFFFF, 0);
    beat(hdr1(32'h0000_0011), 16'hFFFF, 0);
    beat(P0E, 16'hFFFF, 0);
    beat(P1E, 16'hFFFF, 0);
    chk("mid_skid_full", s_tready, 0);
    rst = 1; cyc(); rst = 0;
    chk("mid_rst_vld", m_tvalid, 0);
    chk("mid_rst_rdy", s_tready, 1);
    chk("mid_rst_seq", seq_number, 0);
    m_tready = 1;
    beat(H0, 16'hFFFF, 0);
    chk("mid_h0_nofwd", m_tvalid, 0);
    beat(hdr1(32'h0000_0022), 16'hFFFF, 0);
    chk("mid_h1_nofwd", m_tvalid, 0);
    chk("mid_seq", seq_number, 32'h22);
    beat(P0F, 16'hFFFF, 1);
    chk("mid_p0_data", m_tdata, P0F);
    chk("mid_count", packet_count, 1);
    cyc();
    chk("mid_idle", m_tvalid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/si_payload_extractor.md
Name: si_payload_extractor

Overview:
- Sits directly downstream of the header parser, on the same 128-bit AXI4-Stream.
- Consumes the two 16-byte header beats of every accepted time-tag packet and captures the 32-bit sequence number as sideband.
- Forwards only payload beats (two 64-bit tags per beat) to the tag-conversion stage, through a registered full-throughput output slice.
- Flags runt packets and misaligned payload beats for debugging.

Parameters:
- HEADER_WORDS, 2, number of leading beats per packet treated as header and never forwarded. Legal values are 2 and 3 only.
- SEQ_WORD, 1, header beat index (0-based) that carries the sequence number.
- SEQ_LSB, 64, bit offset of the sequence number inside beat SEQ_WORD. The field is tdata[SEQ_LSB+:32], i.e. packet bytes 24-27.

Ports:
- s_axis.clk, input, 1: the single clock; all logic is on its rising edge.
- s_axis.rst, input, 1: reset, synchronous and active-high.
- s_axis, axis_interface.slave, 128-bit data / 16-bit keep: input packet stream.
- m_axis, axis_interface.master, 128-bit data / 16-bit keep: payload-only output stream. tuser is tied to 0.
- seq_number, output, 32: sequence number of the most recent packet; held until the next one.
- seq_valid, output, 1: one-cycle pulse when seq_number updates.
- runt_packet, output, 1: one-cycle pulse when tlast arrives at or before header beat HEADER_WORDS-1.
- misaligned_tag, output, 1: one-cycle pulse when a payload beat has tkeep not equal to 16'h00FF or 16'hFFFF.
- packet_count, output, 32: count of packets with at least one forwarded payload beat; wraps 0xFFFFFFFF -> 0.

Behaviour:
- Reset values:
  - state = HDR, word_idx = 0.
  - m_axis.tvalid = 0, skid empty, s_axis.tready = 1 on the first post-reset cycle.
  - seq_number = 0, seq_valid = runt_packet = misaligned_tag = 0, packet_count = 0.
  - Reset mid-packet discards all buffered beats. The next accepted beat is header beat 0 (the upstream parser shares this reset).
- State machine, advancing only on accepted beats (s_axis.tvalid && s_axis.tready):
  - HDR: word_idx increments 0..HEADER_WORDS-1. On the beat where word_idx == HEADER_WORDS-1 and tlast = 0, go to PAYLOAD.
  - PAYLOAD: each beat is forwarded. tlast -> HDR, word_idx = 0.
  - tlast in HDR -> runt_packet pulse next cycle, stay in HDR, word_idx = 0, nothing forwarded.
- Header beats:
  - Consumed whenever s_axis.tready = 1, independent of m_axis.tready.
  - No tkeep check in this block; upstream already validated.
- Sequence capture: on the accepted beat with word_idx == SEQ_WORD in HDR, register seq_number = tdata[SEQ_LSB+:32] and pulse seq_valid the next cycle. This happens even if the packet later turns out to be a runt.
- Output slice:
  - Main register plus one skid register.
  - s_axis.tready is a register output, equal to "skid empty".
  - Latency is 1 cycle from input acceptance to m_axis.tvalid.
  - Throughput is 1 beat/cycle while m_axis.tready = 1.
  - When m_axis.tready drops, at most one extra beat lands in the skid; s_axis.tready falls the following cycle.
  - tdata, tkeep and tlast pass unmodified; no output fields change while m_axis.tvalid = 1 and m_axis.tready = 0.
  - Beat order is preserved; skid drains before main is refilled from input.
- Counters and flags:
  - packet_count increments when the first payload beat of a packet is accepted.
  - misaligned_tag is evaluated on accepted payload beats; the beat is still forwarded.
  - Simultaneous events: seq_valid and runt_packet may pulse in the same cycle (runt at beat SEQ_WORD). Pulses never merge across packets.
- Single-beat payload (tlast on first payload beat) produces exactly one output beat with tlast = 1.

Decomposition:
- Package si_payload_pkg holds:
  - typedef enum {HDR, PAYLOAD} payload_state_t.
  - Constants TAG_WIDTH = 64, TAGS_PER_BEAT = 2, KEEP_ONE_TAG = 16'h00FF, KEEP_TWO_TAGS = 16'hFFFF.
  - Default header constants HEADER_WORDS_DEFAULT = 2 and SEQ_LSB_DEFAULT = 64.
- Sub-module si_axis_skid_slice: a generic 2-entry register slice (data, keep, last) with registered upstream ready. It is reused by other stages.

Test Plan:
- Packet of 2 header beats + 3 payload beats, seq bytes = 32'h0000_0005, m_axis.tready = 1 -> 3 output beats on consecutive cycles, first one cycle after payload beat 0 is accepted; last has tlast; seq_number = 5 with one seq_valid pulse; packet_count = 1.
- Same packet with m_axis.tready toggling 1,0,0,1,0,1 -> identical 3 beats, no duplication or loss, tdata stable while stalled; s_axis.tready low for exactly the cycles the skid is full.
- Runt: tlast on header beat 1 with seq = 32'h0000_0009 -> no m_axis.tvalid; runt_packet and seq_valid both pulse once; packet_count unchanged; next valid packet is parsed correctly.
- Payload beat tkeep = 16'h000F -> beat forwarded unchanged, misaligned_tag pulses once; tkeep = 16'h00FF -> no pulse.
- packet_count preloaded via 2^32-1 packets (or force) then one packet -> wraps to 0.
- Reset asserted while the skid holds a beat mid-packet -> m_axis.tvalid = 0 the cycle after reset; the following packet's first 2 beats are treated as header, and its seq is captured.
